// File: rtl/edge_pulse_bank.sv
// edge_pulse_bank
// Multi-channel edge-to-pulse converter. Each channel synchronises an asynchronous
// level, optionally debounces it, detects the selected edge type and stretches the
// detection into a PULSE_LEN-cycle registered pulse. Channels are fully independent.
//
// Build option: define EDGE_PULSE_BANK_DEBOUNCE_EN to include the debounce counter.
// Without it the accepted level follows the synchroniser output every cycle, so any
// synchronised transition (even a one-cycle glitch) is treated as an edge.
//
// Per-channel mode (mode[2i+1:2i]): 00 rising, 01 falling, 10 both, 11 detection off
// (level_out still tracks). mode is sampled combinationally on the cycle the accepted
// level changes; it never affects a pulse that is already running.

module edge_pulse_bank #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_LEN       = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [CHANNELS-1:0]     sig_in,
    input  logic [2*CHANNELS-1:0]   mode,
    output logic [CHANNELS-1:0]     level_out,
    output logic [CHANNELS-1:0]     pulse_out
);

    // Pulse down-counter sized so PULSE_LEN itself is representable.
    localparam int              PL_W       = $clog2(PULSE_LEN) + 1;
    localparam logic [PL_W-1:0] PULSE_LOAD = PL_W'(PULSE_LEN);

`ifdef EDGE_PULSE_BANK_DEBOUNCE_EN
    // Debounce counter counts consecutive samples that disagree with the accepted level.
    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
`else
    // DEBOUNCE_CYCLES has no effect in this build; referenced here only so both
    // builds share one parameter list without an unused-parameter complaint.
    if (DEBOUNCE_CYCLES < 1) begin : g_debounce_cycles_unused
    end
`endif

    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_BOTH = 2'b10,
        MODE_OFF  = 2'b11
    } edge_mode_e;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan

        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync_bit;
        logic                   level_q;
        logic                   level_d;
        logic                   level_rise;
        logic                   level_fall;
        edge_mode_e             ch_mode;
        logic                   edge_q;
        logic                   edge_d;
        logic [PL_W-1:0]        count_q;
        logic [PL_W-1:0]        count_d;
        logic                   pulse_q;

        // Synchroniser chain: bit 0 samples the raw input, top bit is the usable level.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in[gi]};
            end
        end

        assign sync_bit = sync_q[SYNC_STAGES-1];

`ifdef EDGE_PULSE_BANK_DEBOUNCE_EN
        logic [DB_W-1:0] db_cnt_q;
        logic [DB_W-1:0] db_cnt_d;

        // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
        always_comb begin
            level_d  = level_q;
            db_cnt_d = '0;
            if (sync_bit != level_q) begin
                if (db_cnt_q == DB_LAST) begin
                    level_d  = sync_bit;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
        end

        // Debounce counter register.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_d;
            end
        end
`else
        // No filtering: the accepted level is the synchroniser output, one cycle later.
        always_comb begin
            level_d = sync_bit;
        end
`endif

        // Accepted level register.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                level_q <= 1'b0;
            end else begin
                level_q <= level_d;
            end
        end

        // Transition of the accepted level happening on this edge (old level_q vs new level_d).
        assign level_rise = !level_q &&  level_d;
        assign level_fall =  level_q && !level_d;
        assign ch_mode    = edge_mode_e'(mode[2*gi+1:2*gi]);

        // Qualify the transition with the channel's current edge selection.
        always_comb begin
            edge_d = 1'b0;
            case (ch_mode)
                MODE_RISE: edge_d = level_rise;
                MODE_FALL: edge_d = level_fall;
                MODE_BOTH: edge_d = level_rise | level_fall;
                MODE_OFF:  edge_d = 1'b0;
                default:   edge_d = 1'b0;
            endcase
        end

        // Stretcher: a detection (re)loads the full length, so retriggers merge without a gap.
        always_comb begin
            count_d = count_q;
            if (edge_q) begin
                count_d = PULSE_LOAD;
            end else if (count_q != '0) begin
                count_d = count_q - PL_W'(1);
            end
        end

        // Detection flag, stretch counter and registered pulse output.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                edge_q  <= 1'b0;
                count_q <= '0;
                pulse_q <= 1'b0;
            end else begin
                edge_q  <= edge_d;
                count_q <= count_d;
                pulse_q <= (count_d != '0);
            end
        end

        assign level_out[gi] = level_q;
        assign pulse_out[gi] = pulse_q;
    end

endmodule

// File: tb/tb_edge_pulse_bank.sv
// tb_edge_pulse_bank
// Scoreboard bench for edge_pulse_bank (CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// PULSE_LEN=8). Each driven input change pushes the expected level-change cycle and the
// expected pulse window onto per-channel queues; a negedge monitor pops and compares them
// as level_out / pulse_out events are observed. Follows EDGE_PULSE_BANK_DEBOUNCE_EN.

module tb_edge_pulse_bank;

    localparam int CH = 4;
    localparam int S  = 2;
    localparam int DB = 4;
    localparam int PL = 8;
`ifdef EDGE_PULSE_BANK_DEBOUNCE_EN
    localparam int D = DB;
`else
    localparam int D = 1;
`endif

    logic              clk     = 1'b0;
    logic              reset_n = 1'b1;
    logic [CH-1:0]     sig_in  = '0;
    logic [2*CH-1:0]   mode    = '0;
    logic [CH-1:0]     level_out;
    logic [CH-1:0]     pulse_out;

    edge_pulse_bank #(
        .CHANNELS        (CH),
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (DB),
        .PULSE_LEN       (PL)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sig_in    (sig_in),
        .mode      (mode),
        .level_out (level_out),
        .pulse_out (pulse_out)
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge n, cyc == n.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    // Scoreboard queues per channel.
    int lv_cyc_q [CH][$];
    int lv_val_q [CH][$];
    int ps_q     [CH][$];
    int pl_q     [CH][$];
    bit acc      [CH];

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Input change on channel ch to value v, first sampled at edge k.
    task automatic push_change(input int ch, input bit v, input int k);
        logic [1:0] m;
        bit         hit;
        int         s;
        int         n;
        lv_cyc_q[ch].push_back(k + S - 1 + D);
        lv_val_q[ch].push_back(int'(v));
        m   = mode[2*ch +: 2];
        hit = (m == 2'b10) || (m == 2'b00 && v) || (m == 2'b01 && !v);
        if (hit) begin
            s = k + S + D;
            n = ps_q[ch].size();
            if (n > 0 && s <= ps_q[ch][n-1] + pl_q[ch][n-1]) begin
                pl_q[ch][n-1] = s + PL - ps_q[ch][n-1];
            end else begin
                ps_q[ch].push_back(s);
                pl_q[ch].push_back(PL);
            end
        end
    endtask

    // Apply vec, hold it for hold cycles. Entry/exit phase: 2 time units after a rising edge.
    task automatic drive(input logic [CH-1:0] vec, input int hold);
        for (int c = 0; c < CH; c++) begin
            if (vec[c] != acc[c] && hold >= D) begin
                push_change(c, vec[c], cyc + 1);
                acc[c] = vec[c];
            end
        end
        sig_in = vec;
        repeat (hold) @(posedge clk);
        #2;
    endtask

    // Asynchronous reset assertion mid-cycle; trims expected pulses to the kill point.
    task automatic reset_assert();
        reset_n = 1'b0;
        #1;
        check_val("rst_pulse_async", int'(pulse_out), 0);
        check_val("rst_level_async", int'(level_out), 0);
        for (int c = 0; c < CH; c++) begin
            int ns[$];
            int nl[$];
            for (int i = 0; i < ps_q[c].size(); i++) begin
                if (ps_q[c][i] < cyc) begin
                    ns.push_back(ps_q[c][i]);
                    nl.push_back((pl_q[c][i] < cyc - ps_q[c][i]) ? pl_q[c][i] : cyc - ps_q[c][i]);
                end
            end
            ps_q[c] = ns;
            pl_q[c] = nl;
            if (acc[c]) begin
                lv_cyc_q[c].push_back(cyc);
                lv_val_q[c].push_back(0);
            end
            acc[c] = 1'b0;
        end
    endtask

    task automatic reset_release();
        reset_n = 1'b1;
        for (int c = 0; c < CH; c++) begin
            if (sig_in[c]) begin
                push_change(c, 1'b1, cyc + 1);
                acc[c] = 1'b1;
            end
        end
    endtask

    // Monitor: one line per observed pulse, compare every event against the scoreboard.
    bit mon_lvl   [CH];
    bit mon_pulse [CH];
    int start_obs [CH];

    always @(negedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (level_out[c] != mon_lvl[c]) begin
                if (lv_cyc_q[c].size() == 0) begin
                    check_val($sformatf("lvl%0d_unexpected", c), cyc, -1);
                end else begin
                    check_val($sformatf("lvl%0d_cycle", c), cyc, lv_cyc_q[c].pop_front());
                    check_val($sformatf("lvl%0d_value", c), int'(level_out[c]), lv_val_q[c].pop_front());
                end
                mon_lvl[c] = level_out[c];
            end
            if (pulse_out[c] && !mon_pulse[c]) begin
                start_obs[c] = cyc;
            end
            if (!pulse_out[c] && mon_pulse[c]) begin
                $display("ch%0d pulse start %0d len %0d", c, start_obs[c], cyc - start_obs[c]);
                if (ps_q[c].size() == 0) begin
                    check_val($sformatf("pulse%0d_unexpected", c), start_obs[c], -1);
                end else begin
                    check_val($sformatf("pulse%0d_start", c), start_obs[c], ps_q[c].pop_front());
                    check_val($sformatf("pulse%0d_len", c), cyc - start_obs[c], pl_q[c].pop_front());
                end
            end
            mon_pulse[c] = pulse_out[c];
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset.
        #1;
        reset_n = 1'b0;
        #1;
        check_val("por_level", int'(level_out), 0);
        check_val("por_pulse", int'(pulse_out), 0);
        repeat (3) @(posedge clk);
        #2;
        reset_release();

        // Latency and length on ch0, rising mode.
        mode = 8'b00_00_00_00;
        drive(4'b0001, 20);
        drive(4'b0000, 20);

        // Glitch on ch1 in both-edge mode, then a properly held level in rising mode.
        mode = 8'b00_00_10_00;
        drive(4'b0010, 3);
        drive(4'b0000, 20);
        mode = 8'b00_00_00_00;
        drive(4'b0010, 6);
        drive(4'b0000, 20);

        // Mode table: ch0 rise, ch1 fall, ch2 both, ch3 off.
        mode = 8'b11_10_01_00;
        drive(4'b1111, 20);
        drive(4'b0000, 20);

        // Retrigger: ch2 both-edge, transitions 5 cycles apart merge into one pulse.
        mode = 8'b00_10_00_00;
        drive(4'b0100, 5);
        drive(4'b0000, 30);

        // Mid-pulse reset: kill the pulse in its second cycle, no pulse after release.
        drive(4'b0100, S + D + 2);
        check_val("pulse2_live_before_rst", int'(pulse_out[2]), 1);
        reset_assert();
        sig_in = '0;
        repeat (3) @(posedge clk);
        #2;
        reset_release();
        drive(4'b0000, 20);

        // Reset with all inputs held high, then rising pulses on all channels after release.
        mode = 8'b00_00_00_00;
        drive(4'b1111, S + D + 2);
        check_val("pulse_all_live_before_rst", int'(pulse_out), 15);
        reset_assert();
        repeat (3) @(posedge clk);
        #2;
        reset_release();
        drive(4'b1111, 24);

        // Everything pushed must have been observed.
        @(posedge clk);
        #2;
        for (int c = 0; c < CH; c++) begin
            check_val($sformatf("lvl%0d_pending", c), lv_cyc_q[c].size(), 0);
            check_val($sformatf("pulse%0d_pending", c), ps_q[c].size(), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
